axil_tx_stream: RTL
===================

# axil_tx_stream

Downstream stage of the `axi_data_transfer` AXI4-Lite register slave. It takes the slave's decoded register-write strobes, buffers DATA-register writes in a FIFO, and emits them as AXI4-Stream packets of software-programmed length. A status word goes back to the slave's read mux.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: FIFO entries; power of two, 2..128.
- `DATA_WIDTH`, 32: word width; must match the register slave.

Ports:
- `ACLK` in 1: single clock; all logic is rising-edge.
- `ARESETN` in 1: asynchronous, active-low reset.
- `reg_wr_en` in 1: one-cycle write strobe from the register slave.
- `reg_wr_addr` in 2: register index (0 DATA, 1 CTRL, 2 LEN, 3 reserved).
- `reg_wr_data` in DATA_WIDTH: register write value.
- `status` out 32: read-back word; see Operation.
- `pkt_count` out 16: count of completed packets.
- `m_axis_tdata` out DATA_WIDTH: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: last word of a packet.

## Operation
- Writes to index 0 (DATA) push `reg_wr_data` into the FIFO.
  - A push while the FIFO is full is dropped and sets sticky `overflow`.
  - A pop in the same cycle does not rescue a full-FIFO push.
- Writes to index 1 (CTRL):
  - bit0 = start.
  - bit1 = flush.
  - bit2 = clear overflow.
  - Bits are acted on independently in the same write.
- Writes to index 2 (LEN) load `len_reg[15:0]`, the words per packet.
- Writes to index 3 are ignored.
- FSM, IDLE:
  - A start with `len_reg` != 0 loads `remaining = len_reg` and goes to SEND.
  - A start with `len_reg` == 0 is ignored.
  - Flush empties the FIFO and clears the level to 0 in one cycle.
- FSM, SEND:
  - Words are popped from the FIFO into the output register.
  - `remaining` decrements on each handshake (`tvalid && tready`).
  - `tlast` is high with the word for which `remaining` == 1.
  - After that handshake, return to IDLE and increment `pkt_count`.
  - Start and flush are ignored in SEND.
  - A `len_reg` write in SEND only affects the next packet.
- FIFO underrun in SEND: `tvalid` deasserts and the FSM waits. This is not an error.
- AXI4-Stream rules:
  - Once `tvalid` is high, `tdata`, `tlast` and `tvalid` hold until the handshake completes.
  - `tvalid` never depends combinationally on `tready`.
- `status` layout:
  - [7:0] FIFO level.
  - [8] busy (SEND).
  - [9] overflow.
  - [10] full.
  - [11] empty.
  - [31:16] remaining (0 in IDLE).
- `pkt_count` wraps from 0xFFFF to 0.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata` = 0.
  - `pkt_count` = 0.
  - `status` = 0x0000_0800 (empty = 1).
  - FSM in IDLE, `len_reg` = 0, FIFO empty, overflow = 0.
- Reset asserted mid-packet: everything returns to reset values immediately and the FIFO contents are discarded.
- The FIFO level updates on the edge after the strobe.
- Start latency: start sampled at edge k with the FIFO non-empty gives `tvalid` high after edge k+1.
- Data latency: a DATA write sampled at edge k, in SEND with the FIFO and output register empty, gives `tvalid` high after edge k+1.
- Throughput: one word per cycle while `tready` is high and the FIFO is non-empty. There is no bubble between words of one packet.
- Back-to-back packets:
  - The FSM returns to IDLE on the cycle after the last handshake.
  - A new start is accepted from that cycle.
  - A start strobe coinciding with the final handshake is ignored.
- Status bits are registered and reflect state one cycle after the causing edge.

## Configuration
- `AXIL_TX_STREAM_PKTCNT_EN` defined: the 16-bit packet counter is built and drives `pkt_count`.
- `AXIL_TX_STREAM_PKTCNT_EN` undefined: there is no counter register, `pkt_count` is tied to 0, and all other behaviour is identical.

## Test plan
- Basic packet:
  - Stimulus: write LEN=4; push 0x1, 0x2, 0x3, 0x4; CTRL=1; `tready` held high.
  - Response: four consecutive beats 1..4, `tlast` only on 0x4, `pkt_count`=1, `status`[8]=0 afterwards.
- Backpressure:
  - Stimulus: same packet with `tready` toggling 1-0-0-1.
  - Response: data and `tlast` stay stable while stalled, and no word is lost or duplicated.
- Overflow:
  - Stimulus: push 17 words with FIFO_DEPTH=16.
  - Response: level=16, full=1, overflow=1.
  - Follow-up: CTRL=0x4 clears overflow and leaves the level at 16.
- Underrun:
  - Stimulus: LEN=3, push 0xA, start, then push 0xB and 0xC 5 cycles later.
  - Response: 0xA out, `tvalid` low for the gap, then 0xB and 0xC with `tlast` on 0xC.
- Ignored commands:
  - Stimulus: start with LEN=0.
  - Response: stays IDLE.
  - Stimulus: flush during SEND.
  - Response: FIFO untouched.
  - Stimulus: flush in IDLE with level 5.
  - Response: level 0, empty=1.
- Reset mid-packet:
  - Stimulus: assert ARESETN=0 after 2 of 4 beats.
  - Response: outputs go to 0 immediately, `status`=0x800, and no further beats after release.

Source files
------------

// File: rtl/axil_tx_stream.sv
// Buffers AXI4-Lite DATA-register writes in a FIFO and emits them as AXI4-Stream packets.
// Optional packet counter is built when AXIL_TX_STREAM_PKTCNT_EN is defined.
module axil_tx_stream #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  reg_wr_en,
  input  logic [1:0]            reg_wr_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [31:0]           status,
  output logic [15:0]           pkt_count,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [0:0]            state_q, state_d;
  logic [15:0]           len_q, len_d, remaining_q, remaining_d, load_left_q, load_left_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;

  logic wr_data, wr_ctrl, wr_len;
  logic fifo_full, fifo_empty, push, pop, handshake, start, flush, pkt_done;

  assign wr_data    = reg_wr_en && (reg_wr_addr == 2'd0);
  assign wr_ctrl    = reg_wr_en && (reg_wr_addr == 2'd1);
  assign wr_len     = reg_wr_en && (reg_wr_addr == 2'd2);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Fullness is judged on the registered level, so a same-cycle pop cannot make room.
  assign push       = wr_data && !fifo_full;
  assign handshake  = tvalid_q && m_axis_tready;
  // load_left_q stops the output register from fetching words beyond the packet length.
  assign pop        = (state_q == StSend) && (load_left_q != 16'd0) && !fifo_empty &&
                      (!tvalid_q || m_axis_tready);
  assign start      = wr_ctrl && reg_wr_data[0] && (state_q == StIdle) && (len_q != 16'd0);
  assign flush      = wr_ctrl && reg_wr_data[1] && (state_q == StIdle);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (wr_ctrl && reg_wr_data[2]) overflow_d = 1'b0;
    if (wr_data && fifo_full)      overflow_d = 1'b1;
    len_d = wr_len ? reg_wr_data[15:0] : len_q;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    load_left_d = load_left_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    pkt_done    = 1'b0;
    if (handshake) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
    if (pop) begin
      tdata_d     = mem_q[rd_ptr_q];
      tvalid_d    = 1'b1;
      tlast_d     = (load_left_q == 16'd1);
      load_left_d = load_left_q - 16'd1;
    end
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StSend;
          remaining_d = len_q;
          load_left_d = len_q;
        end
      end
      default: begin
        if (handshake) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d     = StIdle;
            remaining_d = 16'd0;
            pkt_done    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= reg_wr_data;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= StIdle;
      len_q       <= '0;
      remaining_q <= '0;
      load_left_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      load_left_q <= load_left_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

`ifdef AXIL_TX_STREAM_PKTCNT_EN
  logic [15:0] pkt_count_q;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)      pkt_count_q <= '0;
    else if (pkt_done) pkt_count_q <= pkt_count_q + 16'd1;
  end
  assign pkt_count = pkt_count_q;
`else
  logic unused_pkt_done;
  assign unused_pkt_done = pkt_done;
  assign pkt_count       = '0;
`endif

  assign status = {remaining_q, 4'b0000, fifo_empty, fifo_full, overflow_q,
                   (state_q == StSend), 8'(count_q)};

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule
